// File: rtl/bcd_binary_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_binary_seq
//  Function : Multi-cycle BCD-to-binary converter (reverse double-dabble).
//             Optional digit validation enabled by defining BCD_BIN_ERR_EN.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      binary_out,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic [SR_W-1:0]    shift_val;
  logic               bad_digit;

  // Shift right, then pull each BCD digit that reached >= 8 back down by 3.
  always_comb begin
    shift_val = sr_q >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (shift_val[BIN_W+4*d +: 4] >= 4'd8) begin
        shift_val[BIN_W+4*d +: 4] = shift_val[BIN_W+4*d +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD_BIN_ERR_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bad_digit) begin
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            sr_d    = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        sr_d  = shift_val;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          bin_d   = shift_val[BIN_W-1:0];
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign binary_out = bin_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_binary_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_binary_seq
//  Function : Scoreboard testbench for bcd_binary_seq (directed vectors).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_binary_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [11:0]       bcd_in = '0;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  binary_out;
  logic              err;

  bcd_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bcd_in     (bcd_in),
    .busy       (busy),
    .done       (done),
    .binary_out (binary_out),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int err;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_single_pulse", int'(prev_done), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %0d expected no completion", binary_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("binary_out", int'(binary_out), e.val);
        chk("err", int'(err), e.err);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
    prev_done = rst_n && done;
  end

  // Issue one start pulse at the next edge; returns the cycle stamp of E0.
  task automatic issue(input logic [11:0] bcd, output int c0);
    @(negedge clk);
    bcd_in = bcd;
    start  = 1'b1;
    @(posedge clk);
    #1 c0 = cyc;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 12'hFFF;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic convert(input logic [11:0] bcd, input int val);
    int c0;
    issue(bcd, c0);
    q.push_back('{val: val, err: 0, cyc: c0 + BIN_W});
    wait_idle();
  endtask

  initial begin
    int c0;

    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_binary_out", int'(binary_out), 0);
    chk("reset_err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    convert(12'h170, 170);
    convert(12'h085, 85);
    convert(12'h999, 999);
    convert(12'h000, 0);
    convert(12'h501, 501);

`ifdef BCD_BIN_ERR_EN
    issue(12'h1A0, c0);
    q.push_back('{val: 0, err: 1, cyc: c0 + 1});
    wait_idle();
    chk("err_busy_after", int'(busy), 0);
    chk("err_hold", int'(err), 1);
`endif

    // A second start while converting must be ignored.
    issue(12'h204, c0);
    q.push_back('{val: 204, err: 0, cyc: c0 + BIN_W});
    repeat (3) @(posedge clk);
    @(negedge clk);
    bcd_in = 12'h999;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_idle();
    repeat (15) @(negedge clk);
    chk("ignored_start_busy", int'(busy), 0);

    // Reset in the middle of a conversion.
    issue(12'h999, c0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_binary_out", int'(binary_out), 0);
    chk("midreset_err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    convert(12'h015, 15);

    // start held high: back-to-back conversions.
    @(negedge clk);
    bcd_in = 12'h012;
    start  = 1'b1;
    @(posedge clk);
    #1 c0 = cyc;
    q.push_back('{val: 12, err: 0, cyc: c0 + BIN_W});
    repeat (BIN_W + 1) @(posedge clk);
    #1 chk("b2b_idle_gap_busy", int'(busy), 0);
    @(posedge clk);
    #1 chk("b2b_restart_busy", int'(busy), 1);
    q.push_back('{val: 12, err: 0, cyc: c0 + 2 * BIN_W + 2});
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("final_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
